// File: rtl/addsub_sequencer.sv
// rtl/addsub_sequencer.sv - operand capture and add/subtract sequencing for a carry-in-less ripple adder
// Keys are synchronized and debounced; subtraction runs as A + ~B followed by + 1.

module addsub_key_debounce #(
   parameter int CYCLES = 500000
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_key_n,
   output logic o_press
);
   localparam int CW = (CYCLES < 2) ? 1 : $clog2(CYCLES + 1);

   logic          r_meta;
   logic          r_sync;
   logic          r_level;
   logic          r_press;
   logic [CW-1:0] r_cnt;

   // r_level is the accepted key level; it flips only after CYCLES differing cycles in a row
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_meta  <= 1'b1;
         r_sync  <= 1'b1;
         r_level <= 1'b1;
         r_press <= 1'b0;
         r_cnt   <= '0;
      end else begin
         r_meta  <= i_key_n;
         r_sync  <= r_meta;
         r_press <= 1'b0;
         if (r_sync == r_level) begin
            r_cnt <= '0;
         end else if (r_cnt == CW'(CYCLES - 1)) begin
            r_cnt   <= '0;
            r_level <= r_sync;
            r_press <= ~r_sync;
         end else begin
            r_cnt <= r_cnt + 1'b1;
         end
      end
   end

   assign o_press = r_press;
endmodule

module addsub_sequencer #(
   parameter int WIDTH           = 5,
   parameter int DEBOUNCE_CYCLES = 500000
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_key_load_n,
   input  logic             i_key_go_n,
   input  logic [WIDTH-1:0] i_sw_operand,
   input  logic             i_sw_mode,
   output logic [WIDTH-1:0] o_add_a,
   output logic [WIDTH-1:0] o_add_b,
   input  logic [WIDTH:0]   i_add_q,
   output logic [WIDTH:0]   o_result,
   output logic             o_result_valid,
   output logic             o_busy,
   output logic [2:0]       o_state
);
   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_WAIT_B = 3'd1,
      S_READY  = 3'd2,
      S_PASS1  = 3'd3,
      S_PASS2  = 3'd4,
      S_DONE   = 3'd5
   } state_t;

   state_t           r_state;
   state_t           w_next_state;
   logic [WIDTH-1:0] r_op_a;
   logic [WIDTH-1:0] r_op_b;
   logic [WIDTH-1:0] r_tmp;
   logic             r_c1;
   logic             r_mode;
   logic [WIDTH:0]   r_result;
   logic             r_valid;

   logic             w_load;
   logic             w_go;
   logic             w_ld_a;
   logic             w_ld_b;
   logic             w_start;
   logic             w_ld_tmp;
   logic             w_ld_res;
   logic [WIDTH:0]   w_res_d;
   logic [WIDTH-1:0] w_add_a;
   logic [WIDTH-1:0] w_add_b;

   addsub_key_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_load_key (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_key_n (i_key_load_n),
      .o_press (w_load)
   );

   addsub_key_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_go_key (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_key_n (i_key_go_n),
      .o_press (w_go)
   );

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   always_comb begin
      w_next_state = r_state;
      w_add_a      = r_op_a;
      w_add_b      = r_op_b;
      w_ld_a       = 1'b0;
      w_ld_b       = 1'b0;
      w_start      = 1'b0;
      w_ld_tmp     = 1'b0;
      w_ld_res     = 1'b0;
      w_res_d      = i_add_q;
      case (r_state)
         S_IDLE: begin
            if (w_load) begin
               w_ld_a       = 1'b1;
               w_next_state = S_WAIT_B;
            end
         end
         S_WAIT_B: begin
            if (w_load) begin
               w_ld_b       = 1'b1;
               w_next_state = S_READY;
            end
         end
         // go takes priority over a coincident load
         S_READY, S_DONE: begin
            if (w_go) begin
               w_start      = 1'b1;
               w_next_state = S_PASS1;
            end else if (w_load) begin
               w_ld_a       = 1'b1;
               w_next_state = S_WAIT_B;
            end
         end
         S_PASS1: begin
            if (r_mode) begin
               w_add_b      = ~r_op_b;
               w_ld_tmp     = 1'b1;
               w_next_state = S_PASS2;
            end else begin
               w_ld_res     = 1'b1;
               w_next_state = S_DONE;
            end
         end
         S_PASS2: begin
            w_add_a      = r_tmp;
            w_add_b      = WIDTH'(1);
            w_ld_res     = 1'b1;
            w_res_d      = {~(r_c1 | i_add_q[WIDTH]), i_add_q[WIDTH-1:0]};
            w_next_state = S_DONE;
         end
         default: w_next_state = S_IDLE;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_op_a   <= '0;
         r_op_b   <= '0;
         r_tmp    <= '0;
         r_c1     <= 1'b0;
         r_mode   <= 1'b0;
         r_result <= '0;
         r_valid  <= 1'b0;
      end else begin
         if (w_ld_a) r_op_a <= i_sw_operand;
         if (w_ld_b) r_op_b <= i_sw_operand;
         if (w_start) r_mode <= i_sw_mode;
         if (w_ld_tmp) begin
            r_tmp <= i_add_q[WIDTH-1:0];
            r_c1  <= i_add_q[WIDTH];
         end
         if (w_ld_res) r_result <= w_res_d;
         if (w_ld_res) begin
            r_valid <= 1'b1;
         end else if (w_ld_a || w_start) begin
            r_valid <= 1'b0;
         end
      end
   end

   assign o_add_a        = w_add_a;
   assign o_add_b        = w_add_b;
   assign o_result       = r_result;
   assign o_result_valid = r_valid;
   assign o_busy         = (r_state == S_PASS1) || (r_state == S_PASS2);
   assign o_state        = r_state;
endmodule
